// File: rtl/dcache_controller.sv
// Direct-mapped, write-back, write-allocate data cache controller.
// 16 lines x 4 words (128-bit lines). A miss stalls the pipeline, writes back
// a dirty victim if needed, refills the line, then replays the access as a hit.
//
// state      | meaning
// -----------+-----------------------------------------------------------
// S_IDLE     | serve hits combinationally; detect misses
// S_WRITEBACK| dirty victim line being written to backing memory
// S_ALLOCATE | requested line being fetched from backing memory
module dcache_controller (
    input  logic         clk_i,
    input  logic         rst_i,
    input  logic         cpu_req_i,
    input  logic         cpu_we_i,
    input  logic [31:0]  cpu_addr_i,
    input  logic [31:0]  cpu_data_i,
    output logic [31:0]  cpu_data_o,
    output logic         cpu_stall_o,
    output logic         mem_req_o,
    output logic         mem_we_o,
    output logic [31:0]  mem_addr_o,
    output logic [127:0] mem_data_o,
    input  logic         mem_ack_i,
    input  logic [127:0] mem_data_i
);

    typedef enum logic [1:0] {
        S_IDLE      = 2'd0,
        S_WRITEBACK = 2'd1,
        S_ALLOCATE  = 2'd2
    } state_t;

    state_t         state_q;
    state_t         state_d;

    logic [15:0]    valid_q;
    logic [15:0]    dirty_q;
    logic [23:0]    tag_q  [16];
    logic [127:0]   data_q [16];

    logic [3:0]     idx;
    logic [1:0]     word;
    logic [23:0]    tag;
    logic [127:0]   line;
    logic           hit;
    logic           victim_dirty;
    logic           store_hit;
    logic           fill_done;
    logic           unused_addr_bits;

    assign idx              = cpu_addr_i[7:4];
    assign word             = cpu_addr_i[3:2];
    assign tag              = cpu_addr_i[31:8];
    assign unused_addr_bits = ^cpu_addr_i[1:0];
    assign line             = data_q[idx];
    assign hit              = cpu_req_i && valid_q[idx] && (tag_q[idx] == tag);
    assign victim_dirty     = valid_q[idx] && dirty_q[idx];

    // State register; valid/dirty bits are the only array state cleared by reset.
    always_ff @(posedge clk_i) begin
        if (!rst_i) begin
            state_q <= S_IDLE;
            valid_q <= '0;
            dirty_q <= '0;
        end else begin
            state_q <= state_d;
            if (fill_done) begin
                valid_q[idx] <= 1'b1;
                dirty_q[idx] <= 1'b0;
            end else if (store_hit) begin
                dirty_q[idx] <= 1'b1;
            end
        end
    end

    // Tag and data storage: line refill on fill ack, word update on store hit.
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            if (fill_done) begin
                tag_q[idx]  <= tag;
                data_q[idx] <= mem_data_i;
            end else if (store_hit) begin
                data_q[idx][{word, 5'b00000} +: 32] <= cpu_data_i;
            end
        end
    end

    // Next-state logic and all outputs; memory ack only matters in the transfer states.
    always_comb begin
        state_d     = state_q;
        cpu_data_o  = 32'd0;
        cpu_stall_o = 1'b0;
        mem_req_o   = 1'b0;
        mem_we_o    = 1'b0;
        mem_addr_o  = 32'd0;
        mem_data_o  = 128'd0;
        store_hit   = 1'b0;
        fill_done   = 1'b0;
        case (state_q)
            S_IDLE: begin
                if (cpu_req_i) begin
                    if (hit) begin
                        if (cpu_we_i) begin
                            store_hit = 1'b1;
                        end else begin
                            cpu_data_o = line[{word, 5'b00000} +: 32];
                        end
                    end else begin
                        cpu_stall_o = 1'b1;
                        state_d     = victim_dirty ? S_WRITEBACK : S_ALLOCATE;
                    end
                end
            end
            S_WRITEBACK: begin
                cpu_stall_o = 1'b1;
                mem_req_o   = 1'b1;
                mem_we_o    = 1'b1;
                mem_addr_o  = {tag_q[idx], idx, 4'b0000};
                mem_data_o  = line;
                if (mem_ack_i) begin
                    state_d = S_ALLOCATE;
                end
            end
            S_ALLOCATE: begin
                cpu_stall_o = 1'b1;
                mem_req_o   = 1'b1;
                mem_addr_o  = {tag, idx, 4'b0000};
                if (mem_ack_i) begin
                    fill_done = 1'b1;
                    state_d   = S_IDLE;
                end
            end
            default: begin
                state_d = S_IDLE;
            end
        endcase
    end

endmodule

// File: doc/dcache_controller.md
DCACHE_CONTROLLER -- requirements
Module: dcache_controller

Interface
REQ-001 The block SHALL have no parameters; geometry is fixed at 16 lines x 4 words (128-bit line), direct-mapped, write-back, write-allocate.
REQ-002 clk_i  input  1  sole clock; all state changes on rising edge.
REQ-003 rst_i  input  1  reset, synchronous, active-low (0 = reset).
REQ-004 cpu_req_i  input  1  MEM-stage access request (MemRead or MemWrite).
REQ-005 cpu_we_i  input  1  1 = store, 0 = load; valid with cpu_req_i.
REQ-006 cpu_addr_i  input  32  byte address; [1:0] ignored, [3:2] word, [7:4] index, [31:8] tag.
REQ-007 cpu_data_i  input  32  store data.
REQ-008 cpu_data_o  output  32  load data; valid when cpu_req_i=1, cpu_we_i=0, cpu_stall_o=0.
REQ-009 cpu_stall_o  output  1  freezes the whole pipeline while 1.
REQ-010 mem_req_o  output  1  backing-memory line request.
REQ-011 mem_we_o  output  1  1 = line write-back, 0 = line fill.
REQ-012 mem_addr_o  output  32  line-aligned address, {tag, index, 4'b0000}.
REQ-013 mem_data_o  output  128  victim line for write-back.
REQ-014 mem_ack_i  input  1  one-cycle completion pulse from memory.
REQ-015 mem_data_i  input  128  fill data; valid in the mem_ack_i cycle of a fill.

Function
REQ-016 Per line: valid bit, dirty bit, 24-bit tag, 128-bit data; word w occupies data bits [32w+31:32w].
REQ-017 FSM states: IDLE, WRITEBACK, ALLOCATE.
REQ-018 Hit = cpu_req_i & valid[index] & (tag[index] == addr[31:8]); evaluated combinationally in IDLE.
REQ-019 Load hit: cpu_data_o = selected word in the same cycle, cpu_stall_o = 0, zero added latency.
REQ-020 Store hit: selected word <= cpu_data_i and dirty <= 1 at the clock edge; cpu_stall_o = 0.
REQ-021 cpu_req_i = 0: no state change, cpu_stall_o = 0, cpu_data_o = 0.
REQ-022 Miss in IDLE: cpu_stall_o = 1 combinationally in that cycle; next state WRITEBACK if victim valid & dirty, else ALLOCATE.
REQ-023 WRITEBACK: mem_req_o = 1, mem_we_o = 1, mem_addr_o = {victim tag, index, 4'b0}, mem_data_o = victim line; all held stable until mem_ack_i; on ack go to ALLOCATE.
REQ-024 ALLOCATE: mem_req_o = 1, mem_we_o = 0, mem_addr_o = {cpu tag, index, 4'b0}; on ack write mem_data_i, set valid = 1, dirty = 0, tag = cpu tag; go to IDLE.
REQ-025 After ALLOCATE the access is re-evaluated in IDLE as a hit; a store miss sets its word and dirty on that hit cycle.
REQ-026 cpu_stall_o = 1 in WRITEBACK and ALLOCATE, including the ack cycle.
REQ-027 The CPU SHALL hold cpu_req_i, cpu_we_i, cpu_addr_i and cpu_data_i stable while cpu_stall_o = 1; the block does not re-latch them.
REQ-028 mem_req_o and mem_we_o = 0 and mem_data_o = 0 in IDLE; mem_ack_i outside WRITEBACK/ALLOCATE is ignored.
REQ-029 Miss penalty = 1 (IDLE decision) + memory latency per transfer (one or two transfers) + 1 (hit cycle).

Reset
REQ-030 rst_i = 0 at a rising edge: all valid and dirty bits cleared, state IDLE; tags/data unspecified.
REQ-031 Outputs during/after reset: mem_req_o = 0, mem_we_o = 0, cpu_stall_o = 0 (unless a request is present and misses), cpu_data_o = 0.
REQ-032 Reset during WRITEBACK or ALLOCATE abandons the transfer; mem_req_o = 0 from the next cycle; a late mem_ack_i is ignored.

Verification
REQ-033 Cold load 0x0000_0104, memory returns line 0x44..._33..._22..._11 after 3 cycles -> stall 5 cycles, no write-back, cpu_data_o = word 1, valid[0] = 1, dirty = 0.
REQ-034 Store 0xDEADBEEF to 0x104 then load 0x104 -> both zero-stall, load returns 0xDEADBEEF, dirty[0] = 1.
REQ-035 Load 0x0000_1104 (same index 0, new tag) after REQ-034 -> WRITEBACK with mem_addr_o = 0x0000_0100, mem_data_o word 1 = 0xDEADBEEF, then ALLOCATE at 0x0000_1100.
REQ-036 Memory with ack held off 10 cycles -> mem_req_o, mem_we_o, mem_addr_o, mem_data_o constant and cpu_stall_o = 1 for the whole wait.
REQ-037 rst_i = 0 for one cycle in ALLOCATE, ack arrives 2 cycles later -> mem_req_o = 0 next cycle, ack ignored, subsequent access to same address misses.
REQ-038 Spurious mem_ack_i pulse in IDLE with cpu_req_i = 0 -> no state, valid, or output change.
